// File: rtl/spi_master_core.sv
// spi_master_core: SPI master, CPOL/CPHA modes, bursts, per-frame config.
// Optional build macro SPI_LSB_FIRST_EN adds cfg_lsb_first.
// Ports:
//   clk, reset         - system clock, async active-low reset
//   cfg_div            - SCK half-period = cfg_div+1 clk
//   cfg_cpol/cpha      - SPI mode
//   cfg_cs_sel         - chip select index for the next frame
//   cfg_lsb_first      - (SPI_LSB_FIRST_EN only) bit order
//   tx_data/empty/rd   - show-ahead TX FIFO head and pop strobe
//   rx_data/wr/full    - RX FIFO push side
//   rx_ovf             - word dropped on full RX FIFO
//   busy               - not idle
//   sck/mosi/miso/cs_n - SPI bus
module spi_master_core #(
  parameter int DATA_W   = 8,
  parameter int CS_NUM   = 1,
  parameter int DIV_W    = 8,
  parameter int HOLD_CYC = 2,
  localparam int SEL_W = (CS_NUM > 1) ?
                         $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [SEL_W-1:0]  cfg_cs_sel,
`ifdef SPI_LSB_FIRST_EN
  input  logic              cfg_lsb_first,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_empty,
  output logic              tx_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_wr,
  input  logic              rx_full,
  output logic              rx_ovf,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_NUM-1:0] cs_n
);

  localparam int TOG_W = $clog2(2*DATA_W+1);
  localparam int RXC_W = $clog2(DATA_W+1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              lsb_in;
  logic [3:0]        hold_cnt;
  logic [TOG_W-1:0]  tog_cnt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_nxt;
  logic [RXC_W-1:0]  rx_cnt;
  logic [1:0]        miso_sync;
  logic [1:0]        samp_pipe;
  logic [CS_NUM-1:0] cs_sel_n;
  logic              tick;
  logic              hold_done;
  logic              last_tog;
  logic              phase_samp;
  logic              samp_ev;
  logic              rx_last;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = cfg_lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(
    input logic [DATA_W-1:0] d,
    input logic              lsb
  );
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(
    input logic [DATA_W-1:0] d,
    input logic              lsb
  );
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  always_comb begin
    cs_sel_n = '1;
    if (int'(cfg_cs_sel) >= CS_NUM)
      cs_sel_n[0] = 1'b0;
    else
      cs_sel_n[cfg_cs_sel] = 1'b0;
  end

  assign tick      = (div_cnt == div_q);
  assign div_nxt   = tick ? '0 : div_cnt + 1'b1;
  assign hold_done = (hold_cnt == 4'(HOLD_CYC-1));
  assign last_tog  = (tog_cnt == TOG_W'(2*DATA_W-1));
  // toggle number is tog_cnt+1; odd toggles sample when cpha=0
  assign phase_samp = ~tog_cnt[0] ^ cpha_q;
  assign samp_ev    = (state == S_XFER) & tick
                    & phase_samp;
  assign busy  = (state != S_IDLE);
  assign tx_rd = reset & ~tx_empty &
                 ((state == S_IDLE) |
                  (state == S_NEXT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      div_q    <= '0;
      div_cnt  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_cnt <= '0;
      tog_cnt  <= '0;
      sh       <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      unique case (state)
        S_IDLE: begin
          sck      <= cfg_cpol;
          div_cnt  <= '0;
          hold_cnt <= '0;
          tog_cnt  <= '0;
          if (!tx_empty) begin
            div_q  <= cfg_div;
            cpol_q <= cfg_cpol;
            cpha_q <= cfg_cpha;
            lsb_q  <= lsb_in;
            cs_n   <= cs_sel_n;
            mosi   <= first_bit(tx_data, lsb_in);
            // cpha=1 re-presents the first bit on toggle 1
            sh     <= cfg_cpha ? tx_data :
                      shift_word(tx_data, lsb_in);
            state  <= S_LEAD;
          end
        end
        S_LEAD: begin
          div_cnt <= div_nxt;
          if (tick) begin
            if (hold_done) begin
              hold_cnt <= '0;
              state    <= S_XFER;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        S_XFER: begin
          div_cnt <= div_nxt;
          if (tick) begin
            sck <= ~sck;
            if (!phase_samp) begin
              mosi <= first_bit(sh, lsb_q);
              sh   <= shift_word(sh, lsb_q);
            end
            if (last_tog)
              state <= S_NEXT;
            else
              tog_cnt <= tog_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          div_cnt <= '0;
          tog_cnt <= '0;
          if (!tx_empty) begin
            sh <= cpha_q ? tx_data :
                  shift_word(tx_data, lsb_q);
            if (!cpha_q)
              mosi <= first_bit(tx_data, lsb_q);
            state <= S_XFER;
          end else begin
            state <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          div_cnt <= div_nxt;
          if (tick) begin
            if (hold_done) begin
              hold_cnt <= '0;
              cs_n     <= '1;
              state    <= S_IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_nxt = lsb_q ?
    {miso_sync[1], rx_sh[DATA_W-1:1]} :
    {rx_sh[DATA_W-2:0], miso_sync[1]};
  assign rx_last = (rx_cnt == RXC_W'(DATA_W-1));

  // miso is captured two clk after its sampling edge so the
  // synchroniser delay is absorbed; the push follows the last capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso_sync <= '0;
      samp_pipe <= '0;
      rx_sh     <= '0;
      rx_cnt    <= '0;
      rx_data   <= '0;
      rx_wr     <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      samp_pipe <= {samp_pipe[0], samp_ev};
      rx_wr     <= 1'b0;
      rx_ovf    <= 1'b0;
      if (samp_pipe[1]) begin
        if (rx_last) begin
          rx_cnt <= '0;
          rx_sh  <= '0;
          if (rx_full) begin
            rx_ovf <= 1'b1;
          end else begin
            rx_wr   <= 1'b1;
            rx_data <= rx_nxt;
          end
        end else begin
          rx_sh  <= rx_nxt;
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: scoreboard bench for spi_master_core.
// Loopback miso=mosi, TX FIFO model, rx and mosi scoreboards.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cfg_div = 8'd1;
  logic       cfg_cpol = 1'b0;
  logic       cfg_cpha = 1'b0;
  logic [1:0] cfg_cs_sel = 2'd0;
`ifdef SPI_LSB_FIRST_EN
  logic       cfg_lsb_first = 1'b0;
`endif
  logic [7:0] tx_data = 8'h00;
  logic       tx_empty = 1'b1;
  logic       tx_rd;
  logic [7:0] rx_data;
  logic       rx_wr;
  logic       rx_full = 1'b0;
  logic       rx_ovf;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [3:0] cs_n;

  assign miso = mosi;

  spi_master_core #(
    .DATA_W(8), .CS_NUM(4), .DIV_W(8), .HOLD_CYC(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_div(cfg_div), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_cs_sel(cfg_cs_sel),
`ifdef SPI_LSB_FIRST_EN
    .cfg_lsb_first(cfg_lsb_first),
`endif
    .tx_data(tx_data), .tx_empty(tx_empty),
    .tx_rd(tx_rd), .rx_data(rx_data),
    .rx_wr(rx_wr), .rx_full(rx_full),
    .rx_ovf(rx_ovf), .busy(busy), .sck(sck),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n_rd = 0;
  int cyc = 0;
  int toggles = 0;
  int last_tog = -1;
  int max_gap = 0;
  int cs_err = 0;
  logic       tb_cpol = 1'b0;
  logic       tb_cpha = 1'b0;
  logic       prev_sck = 1'b0;
  logic [3:0] exp_cs = 4'hF;
  logic [7:0] tx_q[$];
  logic [8:0] rx_exp[$];
  logic       mosi_exp[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // TX FIFO model: pop on tx_rd, refresh head away from the edge
  always @(posedge clk) begin
    if (tx_rd === 1'b1) begin
      if (tx_q.size() > 0) begin
        void'(tx_q.pop_front());
        n_rd++;
      end else begin
        checks++;
        errs++;
        $display("FAIL tx_rd_on_empty actual=1 required=0");
      end
    end
    #1;
    tx_empty = (tx_q.size() == 0);
    tx_data  = tx_empty ? 8'h00 : tx_q[0];
  end

  // monitor: rx scoreboard, mosi scoreboard, sck and cs tracking
  always @(negedge clk) begin
    logic [8:0] e;
    logic       b;
    logic       lead;
    cyc++;
    if (reset) begin
      if (rx_wr === 1'b1 || rx_ovf === 1'b1) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL rx_unexpected actual=%0h required=none",
                   {rx_ovf, rx_wr, rx_data});
        end else begin
          e = rx_exp.pop_front();
          if (e[8])
            check("rx_ovf_flags", {30'd0, rx_ovf, rx_wr}, 32'd2);
          else
            check("rx_word", {22'd0, rx_ovf, rx_wr, rx_data},
                  {22'd0, 2'b01, e[7:0]});
        end
      end
      if (cs_n !== 4'hF && sck !== prev_sck) begin
        toggles++;
        if (last_tog >= 0 && cyc - last_tog > max_gap)
          max_gap = cyc - last_tog;
        last_tog = cyc;
        lead = (prev_sck == tb_cpol);
        if (lead ^ tb_cpha) begin
          if (mosi_exp.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL mosi_extra_edge actual=%0b required=none",
                     mosi);
          end else begin
            b = mosi_exp.pop_front();
            check("mosi_bit", {31'd0, mosi}, {31'd0, b});
          end
        end
      end
      if (busy === 1'b1 && cs_n !== exp_cs)
        cs_err++;
    end
    prev_sck = sck;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic frame(input string tag,
                       input logic cpol, input logic cpha,
                       input logic [7:0] div,
                       input logic [1:0] sel,
                       input logic [7:0] w0,
                       input logic [7:0] w1,
                       input int nw, input logic full,
                       input logic lsb, input logic chg,
                       input int exp_gap);
    logic [7:0] w;
    int rd0;
    step();
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_div = div;
    cfg_cs_sel = sel;
`ifdef SPI_LSB_FIRST_EN
    cfg_lsb_first = lsb;
`endif
    rx_full = full;
    tb_cpol = cpol;
    tb_cpha = cpha;
    exp_cs = ~(4'b0001 << sel);
    toggles = 0;
    last_tog = -1;
    max_gap = 0;
    cs_err = 0;
    rd0 = n_rd;
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 7; i >= 0; i--)
        mosi_exp.push_back(lsb ? w[7-i] : w[i]);
      rx_exp.push_back({full, w});
      tx_q.push_back(w);
    end
    for (int i = 0; i < 50 && busy !== 1'b1; i++) step();
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    if (chg) begin
      cfg_cs_sel = 2'd1;
      cfg_div = 8'd5;
      cfg_cpha = ~cpha;
    end
    for (int i = 0; i < 5000 && busy !== 1'b0; i++) step();
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    repeat (4) step();
    check({tag, "_toggles"}, toggles, 16 * nw);
    check({tag, "_tx_rd"}, n_rd - rd0, nw);
    check({tag, "_gap"}, max_gap, exp_gap);
    check({tag, "_cs_n"}, cs_err, 0);
    check({tag, "_sck_idle"}, {31'd0, sck}, {31'd0, cpol});
    check({tag, "_rx_left"}, rx_exp.size(), 0);
    check({tag, "_mosi_left"}, mosi_exp.size(), 0);
    rx_full = 1'b0;
  endtask

  initial begin
    int rd0;
    repeat (3) step();
    check("rst_cs_n", {28'd0, cs_n}, 32'hF);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_rd", {31'd0, tx_rd}, 32'd0);
    check("rst_rx_wr", {31'd0, rx_wr}, 32'd0);
    check("rst_rx_ovf", {31'd0, rx_ovf}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    cfg_cpol = 1'b1;
    reset = 1'b1;
    step();
    check("sck_after_release", {31'd0, sck}, 32'd1);

    frame("m0_a5", 1'b0, 1'b0, 8'd1, 2'd0, 8'hA5, 8'h00,
          1, 1'b0, 1'b0, 1'b0, 2);
    frame("m3_burst", 1'b1, 1'b1, 8'd2, 2'd0, 8'h3C, 8'hC3,
          2, 1'b0, 1'b0, 1'b0, 4);
    frame("ovf_55", 1'b0, 1'b0, 8'd1, 2'd0, 8'h55, 8'h00,
          1, 1'b1, 1'b0, 1'b0, 2);
    frame("cs2_div0", 1'b0, 1'b1, 8'd0, 2'd2, 8'h69, 8'h00,
          1, 1'b0, 1'b0, 1'b1, 1);
    frame("cs1_next", 1'b0, 1'b0, 8'd1, 2'd1, 8'h0F, 8'h00,
          1, 1'b0, 1'b0, 1'b0, 2);
`ifdef SPI_LSB_FIRST_EN
    frame("lsb_01", 1'b0, 1'b0, 8'd1, 2'd0, 8'h01, 8'h00,
          1, 1'b0, 1'b1, 1'b0, 2);
    cfg_lsb_first = 1'b0;
`endif

    // abort mid-bit 3 in mode 2
    cfg_cpol = 1'b1;
    cfg_cpha = 1'b0;
    cfg_div = 8'd3;
    cfg_cs_sel = 2'd0;
    tb_cpol = 1'b1;
    tb_cpha = 1'b0;
    exp_cs = 4'b1110;
    toggles = 0;
    for (int i = 7; i >= 0; i--)
      mosi_exp.push_back(1'(8'h96 >> i));
    tx_q.push_back(8'h96);
    for (int i = 0; i < 500 && toggles < 7; i++) step();
    check("abort_reach_bit3", toggles, 7);
    reset = 1'b0;
    #1;
    check("abort_cs_n", {28'd0, cs_n}, 32'hF);
    check("abort_sck", {31'd0, sck}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    mosi_exp.delete();
    rx_exp.delete();
    rd0 = n_rd;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("abort_sck_cpol", {31'd0, sck}, 32'd1);
    repeat (6) step();
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_no_pop", n_rd - rd0, 0);
    check("abort_cs_idle", {28'd0, cs_n}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits (4..32).
REQ-002 SHALL have parameter CS_NUM, default 1: number of chip-select outputs (1..8).
REQ-003 SHALL have parameter DIV_W, default 8: width of the clock-divider configuration field.
REQ-004 SHALL have parameter HOLD_CYC, default 2: lead/trail time between CS edge and first/last SCK edge, in SCK half-periods (1..15).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  system clock; the only clock; all logic on posedge clk.
- reset  in  1  asynchronous, active-low reset.
- cfg_div  in  DIV_W  SCK half-period = cfg_div+1 clk cycles.
- cfg_cpol  in  1  SCK idle level.
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cfg_cs_sel  in  clog2(CS_NUM) or 1  index of the CS asserted for the next frame.
- tx_data  in  DATA_W  head of TX FIFO, show-ahead, valid while tx_empty=0.
- tx_empty  in  1  TX FIFO empty.
- tx_rd  out  1  one-cycle pop strobe to TX FIFO.
- rx_data  out  DATA_W  received word, valid when rx_wr=1.
- rx_wr  out  1  one-cycle push strobe to RX FIFO.
- rx_full  in  1  RX FIFO full.
- rx_ovf  out  1  one-cycle pulse: received word dropped.
- busy  out  1  high in any state other than IDLE.
- sck  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in, synchronised with a 2-flop synchroniser.
- cs_n  out  CS_NUM  active-low chip selects.

Function
REQ-006 SHALL implement FSM states IDLE, LEAD, XFER, NEXT, TRAIL.
REQ-007 SHALL generate an internal tick every cfg_div+1 clk cycles; no derived or gated clocks.
REQ-008 SHALL, in IDLE with tx_empty=0, pulse tx_rd, load tx_data into the shifter, latch cfg_cpol/cfg_cpha/cfg_div/cfg_cs_sel, drive cs_n[cs_sel] low, and enter LEAD on the next clk.
REQ-009 SHALL ignore configuration input changes between frame start and return to IDLE.
REQ-010 SHALL stay in LEAD for HOLD_CYC ticks, with sck = cfg_cpol, then enter XFER.
REQ-011 SHALL in XFER toggle sck on each tick, exactly 2*DATA_W toggles per word.
REQ-012 SHALL, for CPHA=0, present the first bit on mosi on entry to LEAD, sample miso on odd toggles and shift on even toggles; for CPHA=1, shift on odd toggles and sample on even toggles.
REQ-013 SHALL transmit MSB first, placing the received word in rx_data with the first received bit as MSB.
REQ-014 SHALL, after the last toggle, enter NEXT for one clk: pulse rx_wr if rx_full=0, otherwise pulse rx_ovf and drop the word.
REQ-015 SHALL, in NEXT with tx_empty=0, pulse tx_rd, reload the shifter, keep cs_n low and re-enter XFER with no lead time (burst); with tx_empty=1, enter TRAIL.
REQ-016 SHALL stay in TRAIL for HOLD_CYC ticks, then deassert cs_n and return to IDLE; busy falls in the same cycle.
REQ-017 SHALL assert at most one cs_n bit at a time, and SHALL treat cfg_cs_sel >= CS_NUM as 0.
REQ-018 SHALL treat cfg_div=0 as SCK = clk/2.
REQ-019 SHALL wrap the bit counter from DATA_W-1 to 0 only through NEXT.

Reset
REQ-020 SHALL, while reset=0, force state=IDLE, sck=0, mosi=0, cs_n=all ones, tx_rd=0, rx_wr=0, rx_ovf=0, busy=0, rx_data=0, and clear shifter, counters and latched configuration.
REQ-021 SHALL, on reset mid-frame, release cs_n immediately with no trailing time, and SHALL pop nothing further; SCK returns to cfg_cpol one clk after reset release.

Configuration
REQ-022 SHALL, with macro SPI_LSB_FIRST_EN defined, add input cfg_lsb_first (latched per frame): 1 shifts LSB first on mosi and fills rx_data from the MSB end down, so that the first received bit lands in bit 0.
REQ-023 SHALL, without SPI_LSB_FIRST_EN, have no cfg_lsb_first port and always use MSB first.

Verification
REQ-024 Mode 0, DATA_W=8, cfg_div=1, TX 0xA5, miso loopback -> 16 sck toggles at 2-clk spacing, mosi 1,0,1,0,0,1,0,1, rx_data=0xA5, exactly one tx_rd and one rx_wr.
REQ-025 Mode 3, TX 0x3C then 0xC3 queued -> cs_n stays low across both words, no LEAD between words, rx_data 0x3C then 0xC3, sck idles high.
REQ-026 rx_full=1 at end of word 0x55 -> rx_ovf pulses once, rx_wr stays 0, frame completes normally.
REQ-027 CS_NUM=4, cfg_cs_sel=2 -> cs_n=4'b1011 during frame; cfg_cs_sel changed to 1 mid-frame -> no effect until the next frame.
REQ-028 reset asserted mid-bit 3 -> cs_n=all ones, sck=0, busy=0 in the same cycle; after release with tx_empty=1 -> IDLE, no tx_rd.
REQ-029 SPI_LSB_FIRST_EN defined, cfg_lsb_first=1, TX 0x01 -> mosi 1 first then seven zeros, loopback rx_data=0x01.
